// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: CPU data-bus view of the interrupt controller register window.
//   bus_addr   - CPU data address (byte address, [1:0] ignored by the slave)
//   bus_wdata  - write data
//   bus_byteen - write byte enables; only 4'b1111 performs a write
//   bus_rd     - one-cycle load strobe, qualifies read side effects
//   bus_rdata  - combinational read data from the slave
// Modports: master (CPU side), slave (controller side).
interface irq_ctrl_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteen;
    logic        bus_rd;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_byteen,
        output bus_rd,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_byteen,
        input  bus_rd,
        output bus_rdata
    );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller in front of the core's single interrupt input.
// Latches rising edges of device lines into PEND, gates them with MASK, and hands out the
// lowest-index enabled pending source through a CLAIM read / COMPLETE write handshake.
// Only one source is in service at a time.
//
// Register window (word offsets from BASE, bus_addr[1:0] ignored):
//   0x00 PEND     R / W1C
//   0x04 MASK     R/W
//   0x08 CLAIM    R  (id+1 of winner, 0 if none or busy; read with bus_rd claims it)
//   0x0C COMPLETE W  (write in-service id+1 to end service)
//   0x10 TRIG     R/W, only when IRQ_CTRL_LEVEL_EN is defined (1 = level-triggered source)
//
// Ports:
//   clk        - clock
//   reset      - synchronous, active-high reset
//   bus        - irq_ctrl_if.slave CPU data bus
//   src_irq    - device interrupt lines
//   interrupt  - registered interrupt request to the CPU
//
// Config macro: IRQ_CTRL_LEVEL_EN enables the TRIG register and level-triggered sources.
module irq_ctrl #(
    parameter int unsigned N_SRC = 8,
    parameter logic [31:0] BASE  = 32'h0000_7F20
) (
    input  logic             clk,
    input  logic             reset,
    irq_ctrl_if.slave        bus,
    input  logic [N_SRC-1:0] src_irq,
    output logic             interrupt
);

    localparam logic [29:0] BaseWord = BASE[31:2];

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic             busy_q, busy_d;
    logic [4:0]       isr_id_q, isr_id_d;
    logic             interrupt_d;

    logic [29:0]      word_addr;
    logic             hit_pend, hit_mask, hit_claim, hit_complete;
    logic             wr_en;
    logic [N_SRC-1:0] enabled;
    logic [N_SRC-1:0] win_oh;
    logic [4:0]       win_id;
    logic             win_valid;
    logic             claim;
    logic [N_SRC-1:0] edge_evt;

    assign word_addr    = bus.bus_addr[31:2];
    assign hit_pend     = (word_addr == BaseWord);
    assign hit_mask     = (word_addr == BaseWord + 30'd1);
    assign hit_claim    = (word_addr == BaseWord + 30'd2);
    assign hit_complete = (word_addr == BaseWord + 30'd3);
    assign wr_en        = (bus.bus_byteen == 4'b1111);

    assign edge_evt  = src_irq & ~src_q;
    assign enabled   = pend_q & mask_q;
    assign win_valid = |enabled;
    // Isolate the lowest set bit: lowest index has highest priority.
    assign win_oh    = enabled & ~(enabled - N_SRC'(1));

    always_comb begin
        win_id = 5'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                win_id = 5'(i);
            end
        end
    end

    // Claim decisions use pre-edge mask/pend, so a same-cycle MASK write cannot affect them.
    assign claim = hit_claim & bus.bus_rd & ~busy_q & win_valid;

`ifdef IRQ_CTRL_LEVEL_EN
    logic             hit_trig;
    logic [N_SRC-1:0] trig_q, trig_d;

    assign hit_trig = (word_addr == BaseWord + 30'd4);

    always_comb begin
        trig_d = trig_q;
        if (wr_en && hit_trig) begin
            trig_d = bus.bus_wdata[N_SRC-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_q <= '0;
        end else begin
            trig_q <= trig_d;
        end
    end
`endif

    always_comb begin
        pend_d      = pend_q;
        mask_d      = mask_q;
        busy_d      = busy_q;
        isr_id_d    = isr_id_q;
        interrupt_d = ~busy_q & win_valid;

        if (wr_en && hit_pend) begin
            pend_d = pend_d & ~bus.bus_wdata[N_SRC-1:0];
        end
        if (wr_en && hit_mask) begin
            mask_d = bus.bus_wdata[N_SRC-1:0];
        end
        if (claim) begin
            pend_d   = pend_d & ~win_oh;
            busy_d   = 1'b1;
            isr_id_d = win_id;
        end else if (wr_en && hit_complete && busy_q &&
                     (bus.bus_wdata[4:0] == isr_id_q + 5'd1)) begin
            busy_d = 1'b0;
        end
        // Applied last so a new edge beats W1C and claim clears on the same bit.
        pend_d = pend_d | edge_evt;
`ifdef IRQ_CTRL_LEVEL_EN
        // Level sources simply track the line; W1C and claim do not touch them.
        pend_d = (pend_d & ~trig_q) | (src_irq & trig_q);
`endif
    end

    always_comb begin
        bus.bus_rdata = 32'd0;
        if (hit_pend) begin
            bus.bus_rdata = 32'(pend_q);
        end else if (hit_mask) begin
            bus.bus_rdata = 32'(mask_q);
        end else if (hit_claim) begin
            if (!busy_q && win_valid) begin
                bus.bus_rdata = {27'd0, win_id + 5'd1};
            end
`ifdef IRQ_CTRL_LEVEL_EN
        end else if (hit_trig) begin
            bus.bus_rdata = 32'(trig_q);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q     <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            busy_q    <= 1'b0;
            isr_id_q  <= 5'd0;
            interrupt <= 1'b0;
        end else begin
            src_q     <= src_irq;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            busy_q    <= busy_d;
            isr_id_q  <= isr_id_d;
            interrupt <= interrupt_d;
        end
    end

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.bus_addr[1:0], bus.bus_wdata};

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    localparam int unsigned NSrc = 8;
    localparam logic [31:0] Base = 32'h0000_7F20;
    localparam logic [31:0] APend = Base + 32'h00;
    localparam logic [31:0] AMask = Base + 32'h04;
    localparam logic [31:0] AClaim = Base + 32'h08;
    localparam logic [31:0] AComp = Base + 32'h0C;
    localparam logic [31:0] ATrig = Base + 32'h10;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [NSrc-1:0] src_irq;
    logic            interrupt;

    irq_ctrl_if bus_if ();

    irq_ctrl #(
        .N_SRC(NSrc),
        .BASE (Base)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if),
        .src_irq  (src_irq),
        .interrupt(interrupt)
    );

    exp_t sb[$];
    int   n_vec;
    int   n_miss;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus_if.bus_addr   = 32'd0;
        bus_if.bus_wdata  = 32'd0;
        bus_if.bus_byteen = 4'b0000;
        bus_if.bus_rd     = 1'b0;
    endtask

    // Load cycle: expected value queued when driven, compared mid-cycle, then the edge applies.
    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        exp_t e;
        bus_if.bus_addr = addr;
        bus_if.bus_rd   = 1'b1;
        sb.push_back('{tag: tag, exp: exp});
        #1;
        e = sb.pop_front();
        check_val(e.tag, bus_if.bus_rdata, e.exp);
        tick();
        bus_idle();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus_if.bus_addr   = addr;
        bus_if.bus_wdata  = data;
        bus_if.bus_byteen = be;
        tick();
        bus_idle();
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        exp_t e;
        sb.push_back('{tag: tag, exp: {31'd0, exp}});
        e = sb.pop_front();
        check_val(e.tag, {31'd0, interrupt}, e.exp);
    endtask

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        src_irq = '0;
        reset   = 1'b1;
        bus_idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk_irq("rst_irq", 1'b0);
        rd("rst_pend", APend, 32'h0);
        rd("rst_mask", AMask, 32'h0);
        rd("rst_claim", AClaim, 32'h0);

        // Single pulse on source 0
        wr(AMask, 32'h01, 4'hF);
        src_irq[0] = 1'b1;
        tick();
        src_irq[0] = 1'b0;
        chk_irq("t1_irq_edge1", 1'b0);
        tick();
        chk_irq("t1_irq_edge2", 1'b1);
        rd("t1_claim", AClaim, 32'd1);
        chk_irq("t1_irq_claim_edge", 1'b1);
        tick();
        chk_irq("t1_irq_fall", 1'b0);
        wr(AComp, 32'd1, 4'hF);
        tick();
        chk_irq("t1_irq_after_comp", 1'b0);

        // Priority between sources 2 and 5
        wr(AMask, 32'hFF, 4'hF);
        src_irq[5] = 1'b1;
        src_irq[2] = 1'b1;
        tick();
        tick();
        rd("t2_claim_a", AClaim, 32'd3);
        rd("t2_claim_busy", AClaim, 32'd0);
        wr(AComp, 32'd3, 4'hF);
        rd("t2_claim_b", AClaim, 32'd6);
        wr(AComp, 32'd6, 4'hF);
        src_irq = '0;
        tick();

        // Masked source still latches
        wr(AMask, 32'h00, 4'hF);
        src_irq[3] = 1'b1;
        tick();
        src_irq[3] = 1'b0;
        rd("t3_pend", APend, 32'h08);
        chk_irq("t3_irq_masked", 1'b0);
        wr(AMask, 32'h08, 4'hF);
        tick();
        chk_irq("t3_irq_unmask", 1'b1);
        wr(APend, 32'h08, 4'hF);
        tick();
        chk_irq("t3_irq_w1c", 1'b0);
        rd("t3_pend_clr", APend, 32'h0);

        // Partial byte enables are not writes; address bits [1:0] are ignored
        wr(AMask, 32'hFF, 4'b0011);
        rd("t3_mask_partial", AMask + 32'd3, 32'h08);

        // Wrong COMPLETE id leaves service in progress
        wr(AMask, 32'h03, 4'hF);
        src_irq[1:0] = 2'b11;
        tick();
        src_irq[1:0] = 2'b00;
        tick();
        rd("t4_claim0", AClaim, 32'd1);
        wr(AComp, 32'd2, 4'hF);
        rd("t4_claim_still_busy", AClaim, 32'd0);
        wr(AComp, 32'd1, 4'hF);
        rd("t4_claim1", AClaim, 32'd2);
        wr(AComp, 32'd2, 4'hF);

        // Edge event beats same-cycle W1C
        wr(AMask, 32'h00, 4'hF);
        src_irq[4] = 1'b1;
        wr(APend, 32'h10, 4'hF);
        src_irq[4] = 1'b0;
        rd("t5_pend_set_wins", APend, 32'h10);

        // Reset while in service
        wr(AMask, 32'h50, 4'hF);
        src_irq[6] = 1'b1;
        tick();
        src_irq[6] = 1'b0;
        rd("t5_claim4", AClaim, 32'd5);
        chk_irq("t5_irq_before_rst", 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_irq("t5_rst_irq", 1'b0);
        rd("t5_rst_pend", APend, 32'h0);
        rd("t5_rst_mask", AMask, 32'h0);
        rd("t5_rst_claim", AClaim, 32'h0);

`ifdef IRQ_CTRL_LEVEL_EN
        // Level-triggered source 1
        wr(ATrig, 32'h02, 4'hF);
        rd("t6_trig", ATrig, 32'h02);
        wr(AMask, 32'h02, 4'hF);
        src_irq[1] = 1'b1;
        tick();
        tick();
        chk_irq("t6_irq", 1'b1);
        rd("t6_claim", AClaim, 32'd2);
        rd("t6_pend_held", APend, 32'h02);
        wr(APend, 32'h02, 4'hF);
        rd("t6_pend_w1c_ignored", APend, 32'h02);
        wr(AComp, 32'd2, 4'hF);
        chk_irq("t6_irq_comp_edge", 1'b0);
        tick();
        chk_irq("t6_irq_reassert", 1'b1);
        src_irq[1] = 1'b0;
        tick();
        rd("t6_pend_drop", APend, 32'h0);
`else
        // TRIG window is not decoded
        wr(ATrig, 32'hFF, 4'hF);
        rd("t6_trig_absent", ATrig, 32'h0);
        rd("t6_mask_untouched", AMask, 32'h0);
`endif

        if (sb.size() != 0) begin
            check_val("sb_drained", 32'(sb.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller that sits between external device interrupt lines and the single `interrupt` input of the `mips` core. It latches source events, applies per-source enables, and selects the highest-priority pending source. It drives the core's interrupt line and arbitrates service through a claim/complete handshake on the CPU data bus. One interrupt is in service at a time; lower source index has higher priority.

## Interface
- `N_SRC`, 8: number of interrupt sources, legal 1..31.
- `BASE`, 32'h0000_7F20: word-aligned base address of the 5-word register window.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `bus_addr` in 32: CPU data address (`m_data_addr`).
- `bus_wdata` in 32: CPU write data.
- `bus_byteen` in 4: write byte enables. A write takes effect only when the value is 4'b1111 and the address hits.
- `bus_rd` in 1: load strobe. It is high for one cycle per load and qualifies CLAIM side effects.
- `bus_rdata` out 32: combinational read data for the addressed register. It is 0 when there is no hit.
- `src_irq` in N_SRC: device interrupt lines.
- `interrupt` out 1: registered request to the CPU.

## Operation
- Register map. `bus_addr[1:0]` is ignored.
  - BASE+0x00 PEND: read returns pending bits. Write-1-clear.
  - BASE+0x04 MASK: read/write enable bits. Reset value is 0.
  - BASE+0x08 CLAIM: a read returns id+1 of the winner, or 0 when there is none.
  - BASE+0x0C COMPLETE: writing the in-service id+1 ends service.
  - BASE+0x10 TRIG: present only under the config macro (see Configuration).
- Unused high bits of every register read as 0.
- State:
  - `src_q`: previous sample of `src_irq`.
  - `pend[N_SRC]`.
  - `mask[N_SRC]`.
  - `busy`: a source is in service.
  - `isr_id[4:0]`.
- Edge event: `src_irq[i] & ~src_q[i]` at a clock edge sets `pend[i]` at that edge.
- Winner: the lowest i with `pend[i] & mask[i]`.
- CLAIM read with `bus_rd=1`, `busy=0` and a winner present:
  - `bus_rdata` = winner+1.
  - At the edge: `pend[winner]` is cleared, `busy` is set and `isr_id` is set to winner.
- CLAIM read with `busy=1` or no winner: returns 0 and changes no state.
- COMPLETE write with `wdata[4:0]` equal to `isr_id`+1 while `busy`: clears `busy`. Any other value is ignored.
- `interrupt` is driven from a register. At each edge it is loaded with `~busy & |(pend & mask)`, using pre-edge values.
- Simultaneous events:
  - An edge event and a PEND W1C on the same bit: set wins.
  - An edge event on the claimed source in the same cycle as the claim: `pend` remains set.
  - A MASK write in the same cycle as a claim: the claim uses the pre-write mask.
- Masking does not discard events: `pend` still latches while `mask=0`.

## Timing
- Reset values: `interrupt`=0, `pend`=0, `mask`=0, `busy`=0, `isr_id`=0, `src_q`=0. If `src_irq` is high when reset releases, it produces an edge event at the first edge after reset.
- Latency: a source that rises before edge k sets `pend` at edge k, and `interrupt` is high after edge k+1.
- `interrupt` falls one edge after a claim, or after `pend` is cleared or the source is masked. It rises again one edge after COMPLETE if an enabled source is still pending.
- `bus_rdata` is valid in the same cycle as the address; it has no wait states.
- Reset asserted mid-service aborts service and clears all state at that edge.

## Configuration
- Macro: `IRQ_CTRL_LEVEL_EN`.
- Defined:
  - The TRIG register exists at BASE+0x10, read/write, reset value 0.
  - `TRIG[i]=1` makes source i level-triggered: `pend[i]` is loaded with `src_irq[i]` every edge.
  - For level sources, W1C and claim have no effect on `pend[i]`; the claim still sets `busy`.
  - A level source that is still high re-raises `interrupt` one edge after COMPLETE.
- Undefined:
  - All sources are edge-triggered.
  - BASE+0x10 is not decoded: it reads as 0 and writes to it are ignored.

## Test plan
- Reset, then set MASK=0x01 and pulse `src_irq[0]` for 1 cycle. Required: `interrupt`=1 two edges later; CLAIM read returns 1; `interrupt`=0 next edge; COMPLETE write of 1 leaves `interrupt`=0.
- Set MASK=0xFF and raise `src_irq[5]` and `src_irq[2]` in the same cycle. Required: first CLAIM returns 3 and a second CLAIM before COMPLETE returns 0; after COMPLETE 3, the next CLAIM returns 6.
- Set MASK=0 and pulse `src_irq[3]`. Required: PEND reads 0x08 and `interrupt` stays 0. Then write MASK=0x08: `interrupt`=1 one edge later. Then PEND W1C 0x08: `interrupt`=0 one edge later.
- Claim source 0, then write COMPLETE=2. Required: `busy` is unchanged, so CLAIM still returns 0 while source 1 is pending.
- Same-cycle PEND W1C 0x10 and a rising edge on `src_irq[4]`. Required: PEND reads 0x10 afterwards. Separately, assert `reset` while `busy=1`: all registers and `interrupt` read 0 after that edge.
- With `IRQ_CTRL_LEVEL_EN` defined, set TRIG=0x02 and MASK=0x02, and hold `src_irq[1]` high. Required: CLAIM returns 2; after COMPLETE 2, `interrupt` re-asserts one edge later; dropping `src_irq[1]` clears PEND bit 1 one edge later.
